// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: register selects, opcodes and the decoded-instruction record.
// The optional macro ALU_ISSUE_BYPASS_EN is consumed by alu_scoreboard and alu_issue_stage.
package alu_pkg;

  localparam int NUM_REGS = 16;

  typedef logic [3:0] regsel_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MOV = 3'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic [1:0]  perci;
    logic        form;
    logic        const_c;
    logic [15:0] constant;
    regsel_t     a_sel;
    regsel_t     b_sel;
    regsel_t     c_sel;
    regsel_t     d_sel;
    regsel_t     y1_sel;
    regsel_t     y2_sel;
    logic [1:0]  write;
  } dec_instr_t;

  // r0 is hardwired, so it never appears in any pending/query mask.
  function automatic logic [NUM_REGS-1:0] sel_onehot(input regsel_t sel, input logic en);
    sel_onehot = '0;
    if (en && (sel != '0)) sel_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-destination bitmap: set on issue, clear on writeback (set wins), hazard = any queried bit pending.
// With ALU_ISSUE_BYPASS_EN, a same-cycle writeback masks its bit out of the hazard query.
module alu_scoreboard
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] set_mask_i,
  input  logic [NUM_REGS-1:0] clr_mask_i,
  input  logic [NUM_REGS-1:0] query_mask_i,
  output logic                hazard_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d, pending_eff;

  always_comb begin
    pending_d    = (pending_q & ~clr_mask_i) | set_mask_i;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

`ifdef ALU_ISSUE_BYPASS_EN
  assign pending_eff = pending_q & ~clr_mask_i;
`else
  assign pending_eff = pending_q;
`endif

  assign hazard_o = |(pending_eff & query_mask_i);

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch/issue: one-entry holding register, 16-entry register file, scoreboard stall on RAW/WAW.
// Optional same-cycle writeback forwarding under ALU_ISSUE_BYPASS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dec_invalid,
  input  logic [2:0]        alu_op,
  input  logic [1:0]        alu_vec_perci,
  input  logic              alu_form,
  input  logic              const_c,
  input  logic [15:0]       constant,
  input  logic [3:0]        a_sel,
  input  logic [3:0]        b_sel,
  input  logic [3:0]        c_sel,
  input  logic [3:0]        d_sel,
  input  logic [3:0]        y1_sel,
  input  logic [3:0]        y2_sel,
  input  logic [1:0]        alu_write,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [2:0]        iss_op,
  output logic [1:0]        iss_perci,
  output logic              iss_form,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [DATA_W-1:0] iss_c,
  output logic [DATA_W-1:0] iss_d,
  output logic [3:0]        iss_y1_sel,
  output logic [3:0]        iss_y2_sel,
  output logic [1:0]        iss_write,
  input  logic              wb0_en,
  input  logic [3:0]        wb0_sel,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [3:0]        wb1_sel,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              illegal
);

  typedef enum logic {S_EMPTY, S_HELD} state_t;

  state_t              state_q, state_d;
  dec_instr_t          hold_q, hold_d, dec;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic                accept, issue, hazard;
  logic [NUM_REGS-1:0] set_mask, clr_mask, query_mask;

  assign dec = '{op: alu_op_t'(alu_op), perci: alu_vec_perci, form: alu_form,
                 const_c: const_c, constant: constant,
                 a_sel: a_sel, b_sel: b_sel, c_sel: c_sel, d_sel: d_sel,
                 y1_sel: y1_sel, y2_sel: y2_sel, write: alu_write};

  assign iss_valid = (state_q == S_HELD) && !hazard;
  assign issue     = iss_valid && iss_ready;
  assign in_ready  = (state_q == S_EMPTY) || issue;
  assign accept    = in_valid && in_ready && !dec_invalid;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    illegal_d = in_valid && in_ready && dec_invalid;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_HELD;
      S_HELD:  if (issue && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept) hold_d = dec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      hold_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      illegal_q <= illegal_d;
    end
  end

  // Port 1 is written last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '{default: '0};
    end else begin
      if (wb0_en && (wb0_sel != '0)) rf_q[wb0_sel] <= wb0_data;
      if (wb1_en && (wb1_sel != '0)) rf_q[wb1_sel] <= wb1_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_reg(input regsel_t sel);
    rd_reg = rf_q[sel];
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb0_en && (wb0_sel == sel) && (sel != '0)) rd_reg = wb0_data;
    if (wb1_en && (wb1_sel == sel) && (sel != '0)) rd_reg = wb1_data;
`endif
  endfunction

  always_comb begin
    iss_a = rd_reg(hold_q.a_sel);
    iss_b = rd_reg(hold_q.b_sel);
    iss_d = rd_reg(hold_q.d_sel);
    iss_c = hold_q.const_c ? {{(DATA_W-16){1'b0}}, hold_q.constant} : rd_reg(hold_q.c_sel);
  end

  assign iss_op     = hold_q.op;
  assign iss_perci  = hold_q.perci;
  assign iss_form   = hold_q.form;
  assign iss_y1_sel = hold_q.y1_sel;
  assign iss_y2_sel = hold_q.y2_sel;
  assign iss_write  = hold_q.write;
  assign illegal    = illegal_q;

  assign set_mask   = issue ? (sel_onehot(hold_q.y1_sel, hold_q.write[0]) |
                               sel_onehot(hold_q.y2_sel, hold_q.write[1])) : '0;
  assign clr_mask   = sel_onehot(wb0_sel, wb0_en) | sel_onehot(wb1_sel, wb1_en);
  assign query_mask = sel_onehot(hold_q.a_sel, 1'b1) | sel_onehot(hold_q.b_sel, 1'b1) |
                      sel_onehot(hold_q.d_sel, 1'b1) | sel_onehot(hold_q.c_sel, !hold_q.const_c) |
                      sel_onehot(hold_q.y1_sel, hold_q.write[0]) |
                      sel_onehot(hold_q.y2_sel, hold_q.write[1]);

  alu_scoreboard u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_mask_i   (set_mask),
    .clr_mask_i   (clr_mask),
    .query_mask_i (query_mask),
    .hazard_o     (hazard)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected issues queued by stimulus, checked by an independent monitor.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, dec_invalid;
  logic [2:0]  alu_op;
  logic [1:0]  alu_vec_perci;
  logic        alu_form, const_c;
  logic [15:0] constant;
  logic [3:0]  a_sel, b_sel, c_sel, d_sel, y1_sel, y2_sel;
  logic [1:0]  alu_write;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_op;
  logic [1:0]  iss_perci;
  logic        iss_form;
  logic [31:0] iss_a, iss_b, iss_c, iss_d;
  logic [3:0]  iss_y1_sel, iss_y2_sel;
  logic [1:0]  iss_write;
  logic        wb0_en, wb1_en;
  logic [3:0]  wb0_sel, wb1_sel;
  logic [31:0] wb0_data, wb1_data;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .dec_invalid(dec_invalid),
    .alu_op(alu_op), .alu_vec_perci(alu_vec_perci), .alu_form(alu_form),
    .const_c(const_c), .constant(constant),
    .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel), .d_sel(d_sel),
    .y1_sel(y1_sel), .y2_sel(y2_sel), .alu_write(alu_write),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_perci(iss_perci), .iss_form(iss_form),
    .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c), .iss_d(iss_d),
    .iss_y1_sel(iss_y1_sel), .iss_y2_sel(iss_y2_sel), .iss_write(iss_write),
    .wb0_en(wb0_en), .wb0_sel(wb0_sel), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_sel(wb1_sel), .wb1_data(wb1_data),
    .illegal(illegal)
  );

  typedef struct {
    logic [31:0] a, b, c, d;
    logic [3:0]  y1, y2;
    logic [1:0]  wr;
    logic [2:0]  op;
    logic [1:0]  perci;
    logic        form;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, b, c, d,
                          input logic [3:0] y1, y2, input logic [1:0] wr);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.d = d;
    e.y1 = y1; e.y2 = y2; e.wr = wr; e.op = op;
    e.perci = op[1:0]; e.form = op[0];
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [3:0] a, b, c, d, y1, y2,
                           input logic [1:0] wr, input logic cc, input logic [15:0] k);
    alu_op = op; alu_vec_perci = op[1:0]; alu_form = op[0];
    a_sel = a; b_sel = b; c_sel = c; d_sel = d; y1_sel = y1; y2_sel = y2;
    alu_write = wr; const_c = cc; constant = k;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the instruction.
  task automatic send(input logic [2:0] op, input logic [3:0] a, b, c, d, y1, y2,
                      input logic [1:0] wr, input logic cc, input logic [15:0] k);
    int n = 0;
    set_instr(op, a, b, c, d, y1, y2, wr, cc, k);
    in_valid = 1'b1;
    dec_invalid = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_cycle(input logic e0, input logic [3:0] s0, input logic [31:0] d0,
                          input logic e1, input logic [3:0] s1, input logic [31:0] d1);
    wb0_en = e0; wb0_sel = s0; wb0_data = d0;
    wb1_en = e1; wb1_sel = s1; wb1_data = d1;
    tick();
    wb0_en = 1'b0; wb1_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL unexpected_issue: got a=0x%0h op=%0d, expected no issue", iss_a, iss_op);
      end else begin
        mon_e = exp_q.pop_front();
        if ({iss_a, iss_b, iss_c, iss_d, iss_y1_sel, iss_y2_sel, iss_write, iss_op, iss_perci, iss_form} !==
            {mon_e.a, mon_e.b, mon_e.c, mon_e.d, mon_e.y1, mon_e.y2, mon_e.wr, mon_e.op, mon_e.perci, mon_e.form}) begin
          miss_cnt++;
          $display("FAIL issue_fields: got a=%h b=%h c=%h d=%h y1=%h y2=%h wr=%b op=%0d pc=%b f=%b, expected a=%h b=%h c=%h d=%h y1=%h y2=%h wr=%b op=%0d pc=%b f=%b",
                   iss_a, iss_b, iss_c, iss_d, iss_y1_sel, iss_y2_sel, iss_write, iss_op, iss_perci, iss_form,
                   mon_e.a, mon_e.b, mon_e.c, mon_e.d, mon_e.y1, mon_e.y2, mon_e.wr, mon_e.op, mon_e.perci, mon_e.form);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dec_invalid = 1'b0; iss_ready = 1'b1;
    wb0_en = 1'b0; wb0_sel = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_sel = '0; wb1_data = '0;
    set_instr(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_iss_valid", {31'b0, iss_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_iss_a", iss_a, 32'd0);
    chk("rst_iss_c", iss_c, 32'd0);
    chk("rst_sel_write", {20'b0, iss_y1_sel, iss_y2_sel, iss_write, iss_op, iss_perci, iss_form}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic read: r3 = 0x11
    wb_cycle(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0);
    push_exp(3'd2, 32'h11, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("latency_valid_n1", {31'b0, iss_valid}, 32'd1);
    tick();

    // RAW stall on r5 released by writeback
    push_exp(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd5, 4'd0, 2'b01);
    send(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 2'b01, 1'b0, 16'h0);
    push_exp(3'd1, 32'h22, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd1, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall", {31'b0, iss_valid}, 32'd0);
      tick();
    end
    wb0_en = 1'b1; wb0_sel = 4'd5; wb0_data = 32'h22;
    @(negedge clk);
`ifdef ALU_ISSUE_BYPASS_EN
    chk("wb_cycle_valid", {31'b0, iss_valid}, 32'd1);
`else
    chk("wb_cycle_valid", {31'b0, iss_valid}, 32'd0);
`endif
    tick();
    wb0_en = 1'b0;
`ifndef ALU_ISSUE_BYPASS_EN
    @(negedge clk);
    chk("release_next_cycle", {31'b0, iss_valid}, 32'd1);
    tick();
`endif

    // Constant C operand ignores pending r7
    push_exp(3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 4'd7, 4'd0, 2'b01);
    send(3'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 2'b01, 1'b0, 16'h0);
    push_exp(3'd4, 32'h0, 32'h0, 32'h0000_8001, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd4, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 16'h8001);
    @(negedge clk);
    chk("const_no_stall", {31'b0, iss_valid}, 32'd1);
    tick();
    wb_cycle(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77);

    // Invalid instruction dropped
    set_instr(3'd6, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    in_valid = 1'b1; dec_invalid = 1'b1;
    tick();
    in_valid = 1'b0; dec_invalid = 1'b0;
    @(negedge clk);
    chk("illegal_pulse", {31'b0, illegal}, 32'd1);
    chk("illegal_no_issue", {31'b0, iss_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("illegal_one_cycle", {31'b0, illegal}, 32'd0);
    tick();
    push_exp(3'd6, 32'h11, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd6, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("after_illegal_issue", {31'b0, iss_valid}, 32'd1);
    tick();

    // Backpressure from the ALU, then accept + issue in one cycle
    iss_ready = 1'b0;
    push_exp(3'd5, 32'h11, 32'h77, 32'h0, 32'h0, 4'd0, 4'd4, 2'b10);
    send(3'd5, 4'd3, 4'd7, 4'd0, 4'd0, 4'd0, 4'd4, 2'b10, 1'b0, 16'h0);
    push_exp(3'd7, 32'h11, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    set_instr(3'd7, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid_high", {31'b0, iss_valid}, 32'd1);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("bp_a_stable", iss_a, 32'h11);
      chk("bp_fields_stable", {23'b0, iss_y2_sel, iss_write, iss_op}, {23'b0, 4'd4, 2'b10, 3'd5});
      tick();
    end
    iss_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_issue", {31'b0, iss_valid}, 32'd1);
    tick();
    wb_cycle(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'h0);

    // Dual writeback collision and r0 write
    wb_cycle(1'b1, 4'd9, 32'hA, 1'b1, 4'd9, 32'hB);
    wb_cycle(1'b1, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'h0);
    push_exp(3'd1, 32'hB, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("collision_issue", {31'b0, iss_valid}, 32'd1);
    tick();

    // Reset mid-operation with a stalled instruction held
    push_exp(3'd2, 32'h0, 32'h0, 32'h0, 32'h0, 4'd6, 4'd0, 2'b01);
    send(3'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 2'b01, 1'b0, 16'h0);
    send(3'd3, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("stall_before_reset", {31'b0, iss_valid}, 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_discard_valid", {31'b0, iss_valid}, 32'd0);
    chk("reset_discard_ready", {31'b0, in_ready}, 32'd1);
    tick();
    push_exp(3'd4, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd4, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("sb_cleared_by_reset", {31'b0, iss_valid}, 32'd1);
    tick();
    wb_cycle(1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'h0);
    push_exp(3'd5, 32'h66, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 2'b00);
    send(3'd5, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    chk("late_wb_written", {31'b0, iss_valid}, 32'd1);
    tick();

    repeat (5) tick();
    chk("exp_queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-fetch and issue stage sitting directly downstream of the ALU instruction decoder. It accepts one decoded ALU instruction per handshake, reads its four source operands from a 16-entry register file, and tracks pending destinations in a scoreboard. It stalls on RAW/WAW hazards and presents a fully resolved operation to the ALU over a valid/ready interface. ALU results return on two writeback ports, which update the register file and clear the scoreboard.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- dec_invalid  in  1  decoder flagged instruction invalid
- alu_op  in  3  operation code
- alu_vec_perci  in  2  vector/carry mode
- alu_form  in  1  instruction form
- const_c  in  1  C operand is the constant
- constant  in  16  immediate
- a_sel, b_sel, c_sel, d_sel  in  4 each  source register selects
- y1_sel, y2_sel  in  4 each  destination selects
- alu_write  in  2  destination enables: bit0 = Y1, bit1 = Y2
- iss_valid  out  1  operation presented to ALU
- iss_ready  in  1  ALU accepts
- iss_op, iss_perci, iss_form  out  3/2/1  registered copies of the decoded fields
- iss_a, iss_b, iss_c, iss_d  out  DATA_W each  resolved operands
- iss_y1_sel, iss_y2_sel, iss_write  out  4/4/2  destinations and enables
- wb0_en, wb0_sel, wb0_data  in  1/4/DATA_W  writeback port 0
- wb1_en, wb1_sel, wb1_data  in  1/4/DATA_W  writeback port 1
- illegal  out  1  one-cycle pulse when an invalid instruction is dropped

## Operation
- One-entry holding register with states EMPTY and HELD.
  - EMPTY to HELD on acceptance (in_valid & in_ready & !dec_invalid).
  - HELD to EMPTY on issue (iss_valid & iss_ready), unless a new instruction is accepted in the same cycle; then the state stays HELD.
- in_ready = EMPTY | (iss_valid & iss_ready).
- Invalid instructions:
  - in_valid & in_ready & dec_invalid consumes the instruction without holding it.
  - illegal pulses on the next cycle.
  - The state is unchanged.
- Register file: 16 x DATA_W. r0 always reads zero, ignores writes, and is never pending.
  - If both writeback ports target the same register, wb1 wins.
- Scoreboard: 16 pending bits.
  - On issue, set the pending bit for each enabled destination with a nonzero select.
  - A writeback clears the pending bit for its select.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Hazard, evaluated while HELD: any of these is pending.
  - a_sel, b_sel or d_sel.
  - c_sel, only when const_c = 0.
  - Any enabled destination (WAW).
- iss_valid = HELD & !hazard.
- Operands:
  - iss_c = zero-extended constant when const_c = 1; otherwise register c_sel.
  - Operands are read combinationally from the register file while HELD, so a later writeback is reflected in them.
- iss_* fields stay stable while iss_valid & !iss_ready.

## Timing
- Reset values:
  - State EMPTY; scoreboard all clear; register file all zero.
  - iss_valid = 0, illegal = 0.
  - All iss_* data/select outputs 0; in_ready = 1.
- Latency: accept in cycle N, earliest iss_valid in N+1.
- Throughput: one instruction per cycle with no hazards.
- A back-to-back dependent instruction sees the scoreboard bit set by its predecessor and stalls.
- Writeback of a pending source in cycle M releases the stall in M+1 without bypass (see Configuration).
- Reset mid-operation discards the held instruction and clears the scoreboard. Any in-flight ALU result arriving afterwards still writes the register file.

## Configuration
- ALU_ISSUE_BYPASS_EN defined:
  - Writeback data with matching select is forwarded onto the operand outputs in the same cycle.
  - The matching pending bit is treated as clear for hazard evaluation, so iss_valid can rise in cycle M.
- ALU_ISSUE_BYPASS_EN undefined:
  - No forwarding; the stall releases in cycle M+1.

## Structure
- Shared package alu_pkg:
  - NUM_REGS = 16.
  - regsel_t (4-bit).
  - alu_op_t enum.
  - Decoded-instruction struct (all decoder outputs).
- Sub-module alu_scoreboard: the pending bitmap with set/clear ports and hazard query. The register file and holding register stay in the top level.

## Test plan
- Reset, then write r3 = 0x11 via wb0, then issue a=3, b=0, c=0, d=0 with no writes -> iss_valid in the cycle after acceptance, iss_a = 0x11, iss_b = 0.
- Issue with y1_sel = 5, alu_write = 01, then one reading a = 5 -> second instruction stalls (iss_valid = 0) until wb0 writes r5 = 0x22.
  - Then iss_a = 0x22: next cycle without bypass, same cycle with ALU_ISSUE_BYPASS_EN.
- const_c = 1, constant = 0x8001, c_sel = 7 with r7 pending -> no stall, iss_c = 0x00008001.
- dec_invalid = 1 -> no iss_valid, illegal pulses exactly one cycle, and the next valid instruction issues normally.
- iss_ready held low 3 cycles with iss_valid high -> iss_* stable, in_ready = 0; then iss_ready = 1 with in_valid = 1 -> accept and issue in the same cycle.
- wb0 and wb1 both write r9 (0xA, 0xB) in the same cycle -> r9 reads 0xB; a write to r0 -> r0 still reads 0.
